pc_sequencer: RTL

Program-counter sequencer for the MIPS_32 fetch stage. Owns the PC register, sequences the instruction-memory request/acknowledge handshake, and steps the PC through the shared `add_One` incrementer. Applies exception, jump and branch redirects by fixed priority, and squashes the in-flight fetch when a redirect arrives mid-request. Sits between the hazard/branch logic and the instruction memory interface.

---
 rtl/pc_seq_pkg.sv | 30 +++
 rtl/pc_sequencer_add_one.sv | 12 +
 rtl/pc_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the MIPS_32 fetch-stage PC sequencer.
// The redirect kinds are numbered in priority order so that a plain
// magnitude compare decides which of two redirects survives.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } seq_state_t;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_BR   = 2'd1,
      RD_JMP  = 2'd2,
      RD_EXC  = 2'd3
   } redir_kind_t;

   localparam int          DEF_SIZE      = 32;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0040;

   // An incoming redirect replaces a held one when it is real and at least
   // as urgent; ties go to the newer request.
   function automatic logic redir_wins(input redir_kind_t incoming,
                                       input redir_kind_t held);
      return (incoming != RD_NONE) && (incoming >= held);
   endfunction

endpackage

// File: rtl/pc_sequencer_add_one.sv
// Shared PC incrementer. Wraps modulo 2^SIZE with no carry out, so the
// word after the top of the address space is address zero.
module add_One #(
   parameter int SIZE = 32
) (
   input  logic [SIZE-1:0] pc,
   output logic [SIZE-1:0] pc_plus1
);

   assign pc_plus1 = pc + SIZE'(1);

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer for the fetch stage: owns the PC, runs the imem req/ack
// handshake, steps the PC through add_One and applies exc/jump/branch
// redirects. A redirect seen while a request is still outstanding is
// parked in the pending register and squashes that fetch when it acks.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              SIZE      = DEF_SIZE,
   parameter logic [SIZE-1:0] RESET_VEC = SIZE'(DEF_RESET_VEC),
   parameter logic [SIZE-1:0] EXC_VEC   = SIZE'(DEF_EXC_VEC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            exc,
   input  logic            jump,
   input  logic [SIZE-1:0] jump_target,
   input  logic            br_taken,
   input  logic [SIZE-1:0] br_target,
   output logic            imem_req,
   output logic [SIZE-1:0] imem_addr,
   input  logic            imem_ack,
   output logic            instr_valid,
   output logic [SIZE-1:0] pc_out,
   output logic [SIZE-1:0] pc_plus1
);

   seq_state_t      state;
   logic [SIZE-1:0] pc;

   redir_kind_t     pend_kind;
   logic [SIZE-1:0] pend_target;

   redir_kind_t     in_kind;
   logic [SIZE-1:0] in_target;
   redir_kind_t     eff_kind;
   logic [SIZE-1:0] eff_target;

   add_One #(
      .SIZE (SIZE)
   ) u_add_one (
      .pc       (pc),
      .pc_plus1 (pc_plus1)
   );

   // Request and address come straight from registers so memory never
   // sees a combinational path from the redirect or stall inputs.
   assign imem_req  = (state == REQ);
   assign imem_addr = pc;

   // Pick the most urgent redirect requested this cycle.
   always_comb begin
      in_kind   = RD_NONE;
      in_target = '0;
      if (exc) begin
         in_kind   = RD_EXC;
         in_target = EXC_VEC;
      end else if (jump) begin
         in_kind   = RD_JMP;
         in_target = jump_target;
      end else if (br_taken) begin
         in_kind   = RD_BR;
         in_target = br_target;
      end
   end

   // Merge this cycle's redirect with the parked one; a lower-priority
   // request never displaces a higher one already waiting.
   always_comb begin
      eff_kind   = pend_kind;
      eff_target = pend_target;
      if (redir_wins(in_kind, pend_kind)) begin
         eff_kind   = in_kind;
         eff_target = in_target;
      end
   end

   // Sequencer FSM: PC, pending redirect and the registered fetch outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_VEC;
         pc_out      <= '0;
         instr_valid <= 1'b0;
         pend_kind   <= RD_NONE;
         pend_target <= '0;
      end else begin
         instr_valid <= 1'b0;
         case (state)
            BOOT: begin
               if (eff_kind != RD_NONE) begin
                  pc <= eff_target;
               end
               pend_kind   <= RD_NONE;
               pend_target <= '0;
               state       <= stall ? HOLD : REQ;
            end
            REQ: begin
               if (imem_ack) begin
                  if (eff_kind != RD_NONE) begin
                     pc <= eff_target;
                  end else begin
                     pc          <= pc_plus1;
                     pc_out      <= pc;
                     instr_valid <= 1'b1;
                  end
                  pend_kind   <= RD_NONE;
                  pend_target <= '0;
                  state       <= stall ? HOLD : REQ;
               end else begin
                  pend_kind   <= eff_kind;
                  pend_target <= eff_target;
               end
            end
            HOLD: begin
               if (eff_kind != RD_NONE) begin
                  pc <= eff_target;
               end
               pend_kind   <= RD_NONE;
               pend_target <= '0;
               if (!stall) begin
                  state <= REQ;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule
